// File: rtl/fetch_ctrl_if.sv
// Y86-64 fetch-stage bus: raw fetch fields, M/W redirect inputs,
// hazard controls, and the registered F/D outputs.
interface fetch_ctrl_if;
  logic [3:0]  f_icode;
  logic [3:0]  f_ifun;
  logic [3:0]  f_rA;
  logic [3:0]  f_rB;
  logic [63:0] f_valC;
  logic [63:0] f_valP;
  logic        f_instr_valid;
  logic        f_imem_error;
  logic        f_hlt;
  logic [3:0]  M_icode;
  logic        M_Cnd;
  logic [63:0] M_valA;
  logic [3:0]  W_icode;
  logic [63:0] W_valM;
  logic        F_stall;
  logic        D_stall;
  logic        D_bubble;
  logic [63:0] PC;
  logic [63:0] F_predPC;
  logic [2:0]  D_stat;
  logic [3:0]  D_icode;
  logic [3:0]  D_ifun;
  logic [3:0]  D_rA;
  logic [3:0]  D_rB;
  logic [63:0] D_valC;
  logic [63:0] D_valP;

  modport master (
    output f_icode, f_ifun, f_rA, f_rB,
    output f_valC, f_valP,
    output f_instr_valid, f_imem_error, f_hlt,
    output M_icode, M_Cnd, M_valA,
    output W_icode, W_valM,
    output F_stall, D_stall, D_bubble,
    input  PC, F_predPC, D_stat,
    input  D_icode, D_ifun, D_rA, D_rB,
    input  D_valC, D_valP
  );

  modport slave (
    input  f_icode, f_ifun, f_rA, f_rB,
    input  f_valC, f_valP,
    input  f_instr_valid, f_imem_error, f_hlt,
    input  M_icode, M_Cnd, M_valA,
    input  W_icode, W_valM,
    input  F_stall, D_stall, D_bubble,
    output PC, F_predPC, D_stat,
    output D_icode, D_ifun, D_rA, D_rB,
    output D_valC, D_valP
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Y86-64 fetch glue: PC select, next-PC prediction, status,
// field cleaning and the F/D pipeline register.
module fetch_ctrl #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input logic         clk,
  input logic         rst_n,
  fetch_ctrl_if.slave bus
);

  localparam logic [3:0] I_HALT = 4'h0;
  localparam logic [3:0] I_NOP  = 4'h1;
  localparam logic [3:0] I_JXX  = 4'h7;
  localparam logic [3:0] I_CALL = 4'h8;
  localparam logic [3:0] I_RET  = 4'h9;
  localparam logic [3:0] R_NONE = 4'hF;

  localparam logic [2:0] S_AOK = 3'd1;
  localparam logic [2:0] S_HLT = 3'd2;
  localparam logic [2:0] S_ADR = 3'd3;
  localparam logic [2:0] S_INS = 3'd4;

  logic [63:0] pc;
  logic [63:0] pred;
  logic [63:0] pred_q;
  logic [2:0]  stat;
  logic        need_regids;
  logic        need_valC;
  logic        err;
  logic [3:0]  c_icode;
  logic [3:0]  c_ifun;
  logic [3:0]  c_rA;
  logic [3:0]  c_rB;
  logic [63:0] c_valC;

  logic [2:0]  d_stat;
  logic [3:0]  d_icode;
  logic [3:0]  d_ifun;
  logic [3:0]  d_rA;
  logic [3:0]  d_rB;
  logic [63:0] d_valC;
  logic [63:0] d_valP;

  // HLT status is derived from icode; the raw flag is redundant
  logic unused_hlt;
  assign unused_hlt = bus.f_hlt;

  // Mispredict outranks ret when both are in flight
  always_comb begin
    pc = pred_q;
    if (bus.M_icode == I_JXX && !bus.M_Cnd)
      pc = bus.M_valA;
    else if (bus.W_icode == I_RET)
      pc = bus.W_valM;
  end

  always_comb begin
    pred = bus.f_valP;
    if (bus.f_icode == I_JXX || bus.f_icode == I_CALL)
      pred = bus.f_valC;
  end

  always_comb begin
    need_regids = 1'b0;
    need_valC   = 1'b0;
    case (bus.f_icode)
      4'h2, 4'h6,
      4'hA, 4'hB: need_regids = 1'b1;
      4'h3, 4'h4,
      4'h5: begin
        need_regids = 1'b1;
        need_valC   = 1'b1;
      end
      4'h7, 4'h8: need_valC = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    stat = S_AOK;
    if (bus.f_imem_error)
      stat = S_ADR;
    else if (!bus.f_instr_valid)
      stat = S_INS;
    else if (bus.f_icode == I_HALT)
      stat = S_HLT;
  end

  assign err     = (stat == S_ADR) || (stat == S_INS);
  assign c_icode = err ? I_NOP : bus.f_icode;
  assign c_ifun  = err ? 4'h0 : bus.f_ifun;
  assign c_rA    = need_regids ? bus.f_rA : R_NONE;
  assign c_rB    = need_regids ? bus.f_rB : R_NONE;
  assign c_valC  = need_valC ? bus.f_valC : 64'h0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      pred_q <= RESET_PC;
    else if (!bus.F_stall)
      pred_q <= pred;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_stat  <= S_AOK;
      d_icode <= I_NOP;
      d_ifun  <= 4'h0;
      d_rA    <= R_NONE;
      d_rB    <= R_NONE;
      d_valC  <= 64'h0;
      d_valP  <= 64'h0;
    end else if (bus.D_stall) begin
      d_stat  <= d_stat;
    end else if (bus.D_bubble) begin
      d_stat  <= S_AOK;
      d_icode <= I_NOP;
      d_ifun  <= 4'h0;
      d_rA    <= R_NONE;
      d_rB    <= R_NONE;
      d_valC  <= 64'h0;
      d_valP  <= 64'h0;
    end else begin
      d_stat  <= stat;
      d_icode <= c_icode;
      d_ifun  <= c_ifun;
      d_rA    <= c_rA;
      d_rB    <= c_rB;
      d_valC  <= c_valC;
      d_valP  <= bus.f_valP;
    end
  end

  assign bus.PC       = pc;
  assign bus.F_predPC = pred_q;
  assign bus.D_stat   = d_stat;
  assign bus.D_icode  = d_icode;
  assign bus.D_ifun   = d_ifun;
  assign bus.D_rA     = d_rA;
  assign bus.D_rB     = d_rB;
  assign bus.D_valC   = d_valC;
  assign bus.D_valP   = d_valP;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: stimulus queues expected values,
// a monitor process pops and compares them against the outputs.
module tb_fetch_ctrl;

  logic clk;
  logic rst_n;

  fetch_ctrl_if bus ();

  fetch_ctrl #(.RESET_PC(64'h0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum int {
    O_PC, O_PRED, O_STAT, O_ICODE, O_IFUN,
    O_RA, O_RB, O_VALC, O_VALP
  } sel_t;

  typedef struct {
    string       name;
    sel_t        sel;
    logic [63:0] val;
  } exp_t;

  exp_t q[$];
  event chk;
  int   n_chk;
  int   n_fail;

  function automatic logic [63:0] observe(sel_t s);
    case (s)
      O_PC:    return bus.PC;
      O_PRED:  return bus.F_predPC;
      O_STAT:  return {61'h0, bus.D_stat};
      O_ICODE: return {60'h0, bus.D_icode};
      O_IFUN:  return {60'h0, bus.D_ifun};
      O_RA:    return {60'h0, bus.D_rA};
      O_RB:    return {60'h0, bus.D_rB};
      O_VALC:  return bus.D_valC;
      default: return bus.D_valP;
    endcase
  endfunction

  initial begin
    n_chk  = 0;
    n_fail = 0;
    forever begin
      @(chk);
      while (q.size() > 0) begin
        exp_t e;
        logic [63:0] got;
        e   = q.pop_front();
        got = observe(e.sel);
        n_chk++;
        if (got !== e.val) begin
          n_fail++;
          $display("FAIL %s: got 0x%0h expected 0x%0h",
                   e.name, got, e.val);
        end
      end
    end
  end

  task automatic expect_v(string n, sel_t s, logic [63:0] v);
    q.push_back('{n, s, v});
  endtask

  task automatic flush();
    ->chk;
    #1;
  endtask

  task automatic set_f(input logic [3:0] ic, input logic [3:0] fn,
                       input logic [3:0] ra, input logic [3:0] rb,
                       input logic [63:0] vc, input logic [63:0] vp);
    bus.f_icode = ic;
    bus.f_ifun  = fn;
    bus.f_rA    = ra;
    bus.f_rB    = rb;
    bus.f_valC  = vc;
    bus.f_valP  = vp;
    bus.f_hlt   = (ic == 4'h0);
  endtask

  task automatic edge_settle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    set_f(4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h1);
    bus.f_instr_valid = 1'b1;
    bus.f_imem_error  = 1'b0;
    bus.M_icode  = 4'h1;
    bus.M_Cnd    = 1'b1;
    bus.M_valA   = 64'h0;
    bus.W_icode  = 4'h1;
    bus.W_valM   = 64'h0;
    bus.F_stall  = 1'b0;
    bus.D_stall  = 1'b0;
    bus.D_bubble = 1'b0;

    repeat (2) @(negedge clk);
    expect_v("rst_pred", O_PRED, 64'h0);
    expect_v("rst_icode", O_ICODE, 64'h1);
    expect_v("rst_rA", O_RA, 64'hF);
    expect_v("rst_stat", O_STAT, 64'h1);
    expect_v("rst_valP", O_VALP, 64'h0);
    flush();
    rst_n = 1'b1;
    #1;
    expect_v("rel_pc", O_PC, 64'h0);
    flush();

    // Sequential OPq
    @(negedge clk);
    set_f(4'h6, 4'h0, 4'h2, 4'h3, 64'h99, 64'h22);
    edge_settle();
    expect_v("opq_pred", O_PRED, 64'h22);
    expect_v("opq_icode", O_ICODE, 64'h6);
    expect_v("opq_rA", O_RA, 64'h2);
    expect_v("opq_rB", O_RB, 64'h3);
    expect_v("opq_valC", O_VALC, 64'h0);
    expect_v("opq_valP", O_VALP, 64'h22);
    expect_v("opq_stat", O_STAT, 64'h1);
    expect_v("opq_pc", O_PC, 64'h22);
    flush();

    // Jump predicts taken
    @(negedge clk);
    set_f(4'h7, 4'h1, 4'h5, 4'h6, 64'h20, 64'h2B);
    edge_settle();
    expect_v("jxx_pred", O_PRED, 64'h20);
    expect_v("jxx_icode", O_ICODE, 64'h7);
    expect_v("jxx_rA", O_RA, 64'hF);
    expect_v("jxx_valC", O_VALC, 64'h20);
    flush();

    // PC override combinations
    @(negedge clk);
    bus.M_icode = 4'h7;
    bus.M_Cnd   = 1'b0;
    bus.M_valA  = 64'h2B;
    #1;
    expect_v("mispred_pc", O_PC, 64'h2B);
    flush();
    bus.W_icode = 4'h9;
    bus.W_valM  = 64'h100;
    #1;
    expect_v("mis_vs_ret_pc", O_PC, 64'h2B);
    flush();
    bus.M_Cnd = 1'b1;
    #1;
    expect_v("taken_ret_pc", O_PC, 64'h100);
    flush();
    bus.M_icode = 4'h1;
    bus.W_valM  = 64'h40;
    #1;
    expect_v("ret_pc", O_PC, 64'h40);
    flush();
    bus.W_icode = 4'h1;
    #1;
    expect_v("pred_pc", O_PC, 64'h20);
    flush();

    // F_stall holds predPC while PC follows mispredict
    @(negedge clk);
    bus.F_stall = 1'b1;
    bus.M_icode = 4'h7;
    bus.M_Cnd   = 1'b0;
    bus.M_valA  = 64'h55;
    set_f(4'h6, 4'h1, 4'h1, 4'h2, 64'h0, 64'h77);
    #1;
    expect_v("fstall_pc", O_PC, 64'h55);
    flush();
    for (int i = 0; i < 3; i++) begin
      edge_settle();
      expect_v("fstall_pred", O_PRED, 64'h20);
      flush();
    end
    expect_v("fstall_dicode", O_ICODE, 64'h6);
    expect_v("fstall_dvalP", O_VALP, 64'h77);
    flush();
    @(negedge clk);
    bus.F_stall = 1'b0;
    bus.M_icode = 4'h1;
    bus.M_Cnd   = 1'b1;

    // Stall wins over bubble
    set_f(4'h3, 4'h0, 4'hF, 4'h4, 64'h1234, 64'h30);
    bus.D_stall  = 1'b1;
    bus.D_bubble = 1'b1;
    edge_settle();
    expect_v("dstall_icode", O_ICODE, 64'h6);
    expect_v("dstall_valP", O_VALP, 64'h77);
    expect_v("dstall_ifun", O_IFUN, 64'h1);
    expect_v("dstall_pred", O_PRED, 64'h30);
    flush();

    @(negedge clk);
    bus.D_stall = 1'b0;
    edge_settle();
    expect_v("bub_icode", O_ICODE, 64'h1);
    expect_v("bub_rA", O_RA, 64'hF);
    expect_v("bub_valP", O_VALP, 64'h0);
    expect_v("bub_valC", O_VALC, 64'h0);
    expect_v("bub_stat", O_STAT, 64'h1);
    flush();

    @(negedge clk);
    bus.D_bubble = 1'b0;
    edge_settle();
    expect_v("irm_icode", O_ICODE, 64'h3);
    expect_v("irm_rB", O_RB, 64'h4);
    expect_v("irm_valC", O_VALC, 64'h1234);
    flush();

    // Call predicts its target
    @(negedge clk);
    set_f(4'h8, 4'h0, 4'h3, 4'h3, 64'h300, 64'h9);
    edge_settle();
    expect_v("call_pred", O_PRED, 64'h300);
    expect_v("call_rA", O_RA, 64'hF);
    flush();

    // Status codes
    @(negedge clk);
    set_f(4'h6, 4'h2, 4'h2, 4'h3, 64'h0, 64'h10);
    bus.f_imem_error = 1'b1;
    edge_settle();
    expect_v("adr_stat", O_STAT, 64'h3);
    expect_v("adr_icode", O_ICODE, 64'h1);
    expect_v("adr_ifun", O_IFUN, 64'h0);
    flush();

    @(negedge clk);
    bus.f_imem_error  = 1'b0;
    bus.f_instr_valid = 1'b0;
    set_f(4'hC, 4'h3, 4'h1, 4'h1, 64'h0, 64'h11);
    edge_settle();
    expect_v("ins_stat", O_STAT, 64'h4);
    expect_v("ins_icode", O_ICODE, 64'h1);
    expect_v("ins_ifun", O_IFUN, 64'h0);
    flush();

    @(negedge clk);
    bus.f_instr_valid = 1'b1;
    set_f(4'h0, 4'h0, 4'h1, 4'h1, 64'h0, 64'h12);
    edge_settle();
    expect_v("hlt_stat", O_STAT, 64'h2);
    expect_v("hlt_icode", O_ICODE, 64'h0);
    flush();

    @(negedge clk);
    set_f(4'h1, 4'h0, 4'h5, 4'h7, 64'hABC, 64'h13);
    edge_settle();
    expect_v("nop_rA", O_RA, 64'hF);
    expect_v("nop_rB", O_RB, 64'hF);
    expect_v("nop_valC", O_VALC, 64'h0);
    expect_v("nop_stat", O_STAT, 64'h1);
    flush();

    // Asynchronous reset mid-cycle
    @(negedge clk);
    set_f(4'h6, 4'h0, 4'h2, 4'h3, 64'h0, 64'h50);
    edge_settle();
    #2;
    rst_n = 1'b0;
    #1;
    expect_v("arst_pred", O_PRED, 64'h0);
    expect_v("arst_icode", O_ICODE, 64'h1);
    expect_v("arst_rA", O_RA, 64'hF);
    expect_v("arst_stat", O_STAT, 64'h1);
    flush();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    expect_v("arel_pc", O_PC, 64'h0);
    flush();
    set_f(4'h6, 4'h0, 4'h2, 4'h3, 64'h0, 64'h0A);
    edge_settle();
    expect_v("arel_pred", O_PRED, 64'h0A);
    expect_v("arel_valP", O_VALP, 64'h0A);
    flush();

    for (int i = 0; i < 10 && q.size() > 0; i++) begin
      ->chk;
      @(negedge clk);
    end
    if (q.size() > 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
